dds_sweep_ctrl: RTL and testbench



---
 rtl/dds_pkg.sv | 21 ++
 rtl/dds_dwell_timer.sv | 39 +++
 rtl/dds_sweep_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller.
//   MODE_*         waveform select codes driven to the DDS core
//   DEF_PINC_W     default phase increment width (matches DDS phase_inc)
//   sweep_state_e  sweep sequencer states
package dds_pkg;

   localparam logic [1:0] MODE_RAMP   = 2'b00;
   localparam logic [1:0] MODE_SQUARE = 2'b01;
   localparam logic [1:0] MODE_SINE   = 2'b10;
   localparam logic [1:0] MODE_MID    = 2'b11;

   localparam int DEF_PINC_W = 30;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter for the sweep sequencer.
//   clk, rst_n   clock / async active-low reset
//   load_i       load load_val_i (takes priority over decrement)
//   load_val_i   dwell value to hold
//   dec_i        decrement by one; saturates at zero
//   zero_o       counter has reached terminal count
module dds_dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [DWELL_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer feeding the DDS core.
//   clk, rst_n                 clock / async active-low reset
//   cfg_start_inc/stop_inc     sweep end points (latched on an accepted start)
//   cfg_step                   unsigned step magnitude
//   cfg_dwell                  each value is held cfg_dwell+1 cycles
//   cfg_mode                   waveform driven during the sweep
//   start / abort              sweep request / cancel
//   phase_inc, mode            registered outputs to the DDS core
//   busy, done, step_strobe    handshake and per-update strobe
// Build option DDS_SWEEP_REPEAT_EN: when the final dwell expires the sweep
// restarts from the start increment (done pulses at each wrap) until abort.
//
// state | meaning
// IDLE  | waiting for start; outputs parked
// DWELL | holding an intermediate value, stepping toward stop on expiry
// FINAL | holding the stop value for its dwell
// DONE  | one-cycle completion pulse, then back to IDLE
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int PINC_W  = DEF_PINC_W,
   parameter int DWELL_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PINC_W-1:0] cfg_start_inc,
   input  logic [PINC_W-1:0] cfg_stop_inc,
   input  logic [PINC_W-1:0] cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]        cfg_mode,
   input  logic              start,
   input  logic              abort,
   output logic [PINC_W-1:0] phase_inc,
   output logic [1:0]        mode,
   output logic              busy,
   output logic              done,
   output logic              step_strobe
);

   sweep_state_e state_q, state_d;

   logic [PINC_W-1:0]  stop_q, stop_d;
   logic [PINC_W-1:0]  step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [1:0]         smode_q, smode_d;
   logic               up_q, up_d;
`ifdef DDS_SWEEP_REPEAT_EN
   logic [PINC_W-1:0]  start_q, start_d;
`endif

   logic [PINC_W-1:0] pinc_q, pinc_d;
   logic [1:0]        mode_q, mode_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              strobe_q, strobe_d;

   logic               tmr_load;
   logic [DWELL_W-1:0] tmr_val;
   logic               tmr_dec;
   logic               tmr_zero;

   // One extra bit catches overflow (up) and borrow (down) so the sweep
   // clamps to stop instead of wrapping around the increment range.
   logic [PINC_W:0]   sum_w, diff_w;
   logic              clamp;
   logic [PINC_W-1:0] next_inc;

   always_comb begin
      sum_w  = {1'b0, pinc_q} + {1'b0, step_q};
      diff_w = {1'b0, pinc_q} - {1'b0, step_q};
      if (up_q) begin
         clamp = sum_w[PINC_W] || (sum_w[PINC_W-1:0] >= stop_q) || (step_q == '0);
         next_inc = clamp ? stop_q : sum_w[PINC_W-1:0];
      end else begin
         clamp = diff_w[PINC_W] || (diff_w[PINC_W-1:0] <= stop_q) || (step_q == '0);
         next_inc = clamp ? stop_q : diff_w[PINC_W-1:0];
      end
   end

   dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      stop_d   = stop_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      smode_d  = smode_q;
      up_d     = up_q;
`ifdef DDS_SWEEP_REPEAT_EN
      start_d  = start_q;
`endif
      pinc_d   = pinc_q;
      mode_d   = mode_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      strobe_d = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = dwell_q;
      tmr_dec  = 1'b0;

      if (abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         pinc_d   = '0;
         mode_d   = MODE_MID;
         busy_d   = 1'b0;
         tmr_load = 1'b1;
         tmr_val  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  stop_d   = cfg_stop_inc;
                  step_d   = cfg_step;
                  dwell_d  = cfg_dwell;
                  smode_d  = cfg_mode;
                  up_d     = (cfg_stop_inc >= cfg_start_inc);
`ifdef DDS_SWEEP_REPEAT_EN
                  start_d  = cfg_start_inc;
`endif
                  pinc_d   = cfg_start_inc;
                  mode_d   = cfg_mode;
                  busy_d   = 1'b1;
                  strobe_d = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = cfg_dwell;
                  state_d  = (cfg_start_inc == cfg_stop_inc) ? FINAL : DWELL;
               end
            end
            DWELL: begin
               if (tmr_zero) begin
                  pinc_d   = next_inc;
                  strobe_d = 1'b1;
                  tmr_load = 1'b1;
                  state_d  = (next_inc == stop_q) ? FINAL : DWELL;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            FINAL: begin
               if (tmr_zero) begin
`ifdef DDS_SWEEP_REPEAT_EN
                  pinc_d   = start_q;
                  strobe_d = 1'b1;
                  done_d   = 1'b1;
                  tmr_load = 1'b1;
                  state_d  = (start_q == stop_q) ? FINAL : DWELL;
`else
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  mode_d  = MODE_MID;
                  state_d = DONE;
`endif
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         stop_q   <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         smode_q  <= MODE_MID;
         up_q     <= 1'b1;
`ifdef DDS_SWEEP_REPEAT_EN
         start_q  <= '0;
`endif
         pinc_q   <= '0;
         mode_q   <= MODE_MID;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         stop_q   <= stop_d;
         step_q   <= step_d;
         dwell_q  <= dwell_d;
         smode_q  <= smode_d;
         up_q     <= up_d;
`ifdef DDS_SWEEP_REPEAT_EN
         start_q  <= start_d;
`endif
         pinc_q   <= pinc_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         strobe_q <= strobe_d;
      end
   end

   // Shadow mode is kept with the rest of the latched config so the sweep
   // mode is recoverable; the output register already carries it.
   logic unused_smode;
   assign unused_smode = ^smode_q;

   assign phase_inc   = pinc_q;
   assign mode        = mode_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign step_strobe = strobe_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl. The reference model expands each sweep
// into the list of expected output events (value strobes, done pulses and the
// spacing between them); a monitor pops and compares whenever the DUT strobes
// or signals done. Also handles builds with DDS_SWEEP_REPEAT_EN defined.
module tb_dds_sweep_ctrl;

   localparam int PW = 30;
   localparam int DW = 16;
   localparam longint PMAX = (longint'(1) << PW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [PW-1:0] cfg_start_inc, cfg_stop_inc, cfg_step;
   logic [DW-1:0] cfg_dwell;
   logic [1:0]    cfg_mode;
   logic          start, abort;
   logic [PW-1:0] phase_inc;
   logic [1:0]    mode;
   logic          busy, done, step_strobe;

   dds_sweep_ctrl #(.PINC_W(PW), .DWELL_W(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start_inc (cfg_start_inc),
      .cfg_stop_inc  (cfg_stop_inc),
      .cfg_step      (cfg_step),
      .cfg_dwell     (cfg_dwell),
      .cfg_mode      (cfg_mode),
      .start         (start),
      .abort         (abort),
      .phase_inc     (phase_inc),
      .mode          (mode),
      .busy          (busy),
      .done          (done),
      .step_strobe   (step_strobe)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit     strobe;
      bit     dn;
      longint pinc;
      int     md;
      bit     bsy;
      int     gap;
   } exp_t;

   exp_t   q[$];
   exp_t   mon_e;
   int     n_checks = 0;
   int     n_pass   = 0;
   longint cyc      = 0;
   longint last_cyc = 0;
   int     n_strobe = 0;

`ifdef DDS_SWEEP_REPEAT_EN
   localparam int REPS = 2;
`else
   localparam int REPS = 1;
`endif

   task automatic chk(input string nm, input longint act, input longint exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
   endtask

   function automatic longint model_next(longint v, longint stop_v, longint st, bit up);
      longint n;
      if (st == 0) return stop_v;
      if (up) begin
         n = v + st;
         return (n >= stop_v) ? stop_v : n;
      end
      n = v - st;
      return (n <= stop_v) ? stop_v : n;
   endfunction

   // Expected event list for one sweep: reps passes of start..stop, each
   // value spaced dwell+1 cycles from the previous event.
   task automatic push_sweep(input longint s, input longint e, input longint st,
                             input int dw, input int md, input int reps);
      longint v;
      bit up;
      up = (e >= s);
      for (int r = 0; r < reps; r++) begin
         v = s;
         q.push_back('{strobe: 1'b1, dn: (r > 0), pinc: v, md: md, bsy: 1'b1,
                       gap: (r == 0) ? 0 : dw + 1});
         while (v != e) begin
            v = model_next(v, e, st, up);
            q.push_back('{strobe: 1'b1, dn: 1'b0, pinc: v, md: md, bsy: 1'b1, gap: dw + 1});
         end
      end
`ifndef DDS_SWEEP_REPEAT_EN
      q.push_back('{strobe: 1'b0, dn: 1'b1, pinc: e, md: 3, bsy: 1'b0, gap: dw + 1});
`endif
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n && (step_strobe || done)) begin
         if (q.size() == 0) begin
            chk("unexpected_event", {step_strobe, done}, 0);
         end else begin
            mon_e = q.pop_front();
            chk("step_strobe", step_strobe, mon_e.strobe);
            chk("done", done, mon_e.dn);
            chk("phase_inc", phase_inc, mon_e.pinc);
            chk("mode", mode, mon_e.md);
            chk("busy", busy, mon_e.bsy);
            if (mon_e.gap != 0) chk("hold_cycles", cyc - last_cyc, mon_e.gap);
            last_cyc = cyc;
            if (step_strobe) n_strobe++;
         end
      end
   end

   // Called shortly after a negedge: present config with start for one edge,
   // then scramble cfg_* to show the latched copy is what the sweep uses.
   task automatic issue(input longint s, input longint e, input longint st,
                        input int dw, input int md);
      cfg_start_inc = PW'(s);
      cfg_stop_inc  = PW'(e);
      cfg_step      = PW'(st);
      cfg_dwell     = DW'(dw);
      cfg_mode      = 2'(md);
      push_sweep(s, e, st, dw, md, REPS);
      start = 1'b1;
      @(posedge clk);
      #1;
      start         = 1'b0;
      cfg_start_inc = PW'($urandom);
      cfg_stop_inc  = PW'($urandom);
      cfg_step      = PW'($urandom);
      cfg_dwell     = DW'($urandom_range(0, 7));
      cfg_mode      = 2'($urandom);
   endtask

   task automatic finish_sweep(input longint e, input int dw);
      int budget;
      budget = (q.size() + 2) * (dw + 2) + 20;
      while (q.size() != 0 && budget > 0) begin
         @(negedge clk);
         #1;
         budget--;
      end
      if (q.size() != 0) begin
         chk("timeout_events_left", q.size(), 0);
         q.delete();
      end
`ifdef DDS_SWEEP_REPEAT_EN
      abort = 1'b1;
      @(negedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_phase_inc", phase_inc, 0);
      chk("abort_mode", mode, 3);
`else
      @(negedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_mode", mode, 3);
      chk("idle_phase_inc", phase_inc, e);
`endif
   endtask

   task automatic do_case(input longint s, input longint e, input longint st,
                          input int dw, input int md);
      issue(s, e, st, dw, md);
      finish_sweep(e, dw);
   endtask

   initial begin
      int     guard;
      int     base_cnt;
      longint rs, re, rst_v, base;
      int     rdw, rmd;

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      cfg_start_inc = '0;
      cfg_stop_inc  = '0;
      cfg_step      = '0;
      cfg_dwell     = '0;
      cfg_mode      = '0;
      repeat (3) @(negedge clk);
      chk("rst_phase_inc", phase_inc, 0);
      chk("rst_mode", mode, 3);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_step_strobe", step_strobe, 0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;

      do_case(100, 130, 10, 2, 2);
      do_case(50, 20, 20, 0, 1);
      do_case(longint'(32'h3FFF_FFF0), longint'(32'h3FFF_FFFF), 32, 1, 0);
      do_case(77, 77, 5, 3, 2);
      do_case(5, 9, 0, 2, 1);

      for (int i = 0; i < 20; i++) begin
         base = ($urandom_range(0, 3) == 0) ? (PMAX - 300) : 0;
         rs   = base + $urandom_range(0, 250);
         re   = base + $urandom_range(0, 250);
         case ($urandom_range(0, 7))
            0:       rst_v = 0;
            1:       rst_v = $urandom_range(200, 1000);
            default: rst_v = $urandom_range(1, 40);
         endcase
         rdw = $urandom_range(0, 4);
         rmd = $urandom_range(0, 2);
         do_case(rs, re, rst_v, rdw, rmd);
      end

      // Abort in the second dwell, with a simultaneous start that must be
      // dropped; a start on the very next cycle must be accepted.
      base_cnt = n_strobe;
      issue(100, 130, 10, 2, 2);
      guard = 50;
      while (n_strobe < base_cnt + 2 && guard > 0) begin
         @(negedge clk);
         #1;
         guard--;
      end
      chk("abort_reached_second_value", n_strobe - base_cnt, 2);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_phase_inc", phase_inc, 0);
      chk("abort_mode", mode, 3);
      chk("abort_done", done, 0);
      chk("abort_step_strobe", step_strobe, 0);
      q.delete();
      do_case(50, 20, 20, 0, 1);

      // Asynchronous reset in the middle of a sweep.
      issue(100, 130, 10, 2, 2);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_phase_inc", phase_inc, 0);
      chk("midrst_mode", mode, 3);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_step_strobe", step_strobe, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      do_case(100, 130, 10, 2, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
